// File: rtl/fifo_to_video_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_to_video_ctrl
// Purpose  : Read side of the DDR frame-buffer path. Pops 128-bit words from a
//            first-word-fall-through FIFO, unpacks each into four 24-bit RGB
//            pixels (alpha bytes dropped) and emits them aligned to the
//            externally supplied vs/hs/de timing, one cycle late. Generates
//            line/frame request pulses that pace the DDR read bursts.
// Ports    : video_clk/video_rst_n   pixel clock, async active-low reset
//            video_{vs,hs,de}_in     timing from the timing generator
//            fifo_data_in/fifo_empty FWFT FIFO head word and empty flag
//            fifo_rd_en              FIFO pop (combinational)
//            video_{vs,hs,de}_out    timing delayed by one cycle
//            video_data_out          pixel, aligned with video_de_out
//            line_req/frame_req      1-cycle pulses on hs/vs rising edge
//            underflow/underflow_clr sticky underflow flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module fifo_to_video_ctrl #(
  parameter logic [23:0] FILL_PIXEL = 24'h000000
) (
  input  logic         video_clk,
  input  logic         video_rst_n,
  input  logic         video_vs_in,
  input  logic         video_hs_in,
  input  logic         video_de_in,
  input  logic [127:0] fifo_data_in,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  output logic         video_vs_out,
  output logic         video_hs_out,
  output logic         video_de_out,
  output logic [23:0]  video_data_out,
  output logic         line_req,
  output logic         frame_req,
  output logic         underflow,
  input  logic         underflow_clr
);

  // Buffer keeps only pixels 1..3; pixel 0 goes straight to the output on pop.
  localparam logic [71:0] c_FILL_BUF = {3{FILL_PIXEL}};

  logic         r_vs_d;
  logic         r_hs_d;
  logic         r_de_d;
  logic [1:0]   r_pix_cnt;
  logic [71:0]  r_buf;
  logic [23:0]  r_data;
  logic         r_line_req;
  logic         r_frame_req;
  logic         r_underflow;

  logic         w_hs_rise;
  logic         w_vs_rise;
  logic [1:0]   w_cnt;
  logic         w_pop_slot;
  logic         w_underrun;
  logic [23:0]  w_buf_pix;
  logic         w_unused_alpha;

  assign w_hs_rise = video_hs_in & ~r_hs_d;
  assign w_vs_rise = video_vs_in & ~r_vs_d;

  // A sync rising edge restarts the word before this cycle is processed, so
  // a de cycle coinciding with the edge is treated as pixel 0 and may pop.
  assign w_cnt      = (w_hs_rise | w_vs_rise) ? 2'd0 : r_pix_cnt;
  assign w_pop_slot = video_de_in & (w_cnt == 2'd0);
  assign w_underrun = w_pop_slot & fifo_empty;
  assign fifo_rd_en = video_rst_n & w_pop_slot & ~fifo_empty;

  // Alpha bytes are deliberately discarded.
  assign w_unused_alpha = &{1'b0, fifo_data_in[127:120], fifo_data_in[95:88],
                            fifo_data_in[63:56], fifo_data_in[31:24]};

  always_comb begin
    w_buf_pix = r_buf[71:48];
    case (w_cnt)
      2'd2:    w_buf_pix = r_buf[47:24];
      2'd3:    w_buf_pix = r_buf[23:0];
      default: w_buf_pix = r_buf[71:48];
    endcase
  end

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      r_vs_d      <= 1'b0;
      r_hs_d      <= 1'b0;
      r_de_d      <= 1'b0;
      r_pix_cnt   <= 2'd0;
      r_buf       <= '0;
      r_data      <= '0;
      r_line_req  <= 1'b0;
      r_frame_req <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_vs_d      <= video_vs_in;
      r_hs_d      <= video_hs_in;
      r_de_d      <= video_de_in;
      r_line_req  <= w_hs_rise;
      r_frame_req <= w_vs_rise;

      if (video_de_in) begin
        r_pix_cnt <= w_cnt + 2'd1;
        if (w_cnt == 2'd0) begin
          if (fifo_empty) begin
            r_buf  <= c_FILL_BUF;
            r_data <= FILL_PIXEL;
          end else begin
            r_buf  <= {fifo_data_in[87:64], fifo_data_in[55:32], fifo_data_in[23:0]};
            r_data <= fifo_data_in[119:96];
          end
        end else begin
          r_data <= w_buf_pix;
        end
      end else begin
        r_pix_cnt <= w_cnt;
        r_data    <= '0;
      end

      // A new underrun wins over a clear in the same cycle.
      if (w_underrun) begin
        r_underflow <= 1'b1;
      end else if (underflow_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign video_vs_out   = r_vs_d;
  assign video_hs_out   = r_hs_d;
  assign video_de_out   = r_de_d;
  assign video_data_out = r_data;
  assign line_req       = r_line_req;
  assign frame_req      = r_frame_req;
  assign underflow      = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_to_video_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_to_video_ctrl
// Purpose  : Self-checking bench for fifo_to_video_ctrl. A FWFT FIFO model
//            feeds the DUT; stimulus pushes expected pixels into a scoreboard
//            queue that a negedge monitor drains whenever video_de_out is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_to_video_ctrl;

  localparam logic [23:0] FILL = 24'hC0FFEE;

  logic         video_clk = 1'b0;
  logic         video_rst_n = 1'b0;
  logic         video_vs_in = 1'b0;
  logic         video_hs_in = 1'b0;
  logic         video_de_in = 1'b0;
  logic [127:0] fifo_data_in = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic         video_vs_out;
  logic         video_hs_out;
  logic         video_de_out;
  logic [23:0]  video_data_out;
  logic         line_req;
  logic         frame_req;
  logic         underflow;
  logic         underflow_clr = 1'b0;

  always #5 video_clk = ~video_clk;

  fifo_to_video_ctrl #(.FILL_PIXEL(FILL)) dut (
    .video_clk      (video_clk),
    .video_rst_n    (video_rst_n),
    .video_vs_in    (video_vs_in),
    .video_hs_in    (video_hs_in),
    .video_de_in    (video_de_in),
    .fifo_data_in   (fifo_data_in),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .video_vs_out   (video_vs_out),
    .video_hs_out   (video_hs_out),
    .video_de_out   (video_de_out),
    .video_data_out (video_data_out),
    .line_req       (line_req),
    .frame_req      (frame_req),
    .underflow      (underflow),
    .underflow_clr  (underflow_clr)
  );

  logic [127:0] fifo_q[$];
  logic [23:0]  exp_q[$];
  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  int lr_cnt = 0;
  int fr_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix(input int n);
    return 24'(n * 70001 + 12345);
  endfunction

  function automatic logic [127:0] mk_word(input logic [23:0] p0, input logic [23:0] p1,
                                           input logic [23:0] p2, input logic [23:0] p3);
    return {8'hA5, p0, 8'h5A, p1, 8'hC3, p2, 8'h3C, p3};
  endfunction

  task automatic fifo_update();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_data_in = fifo_empty ? 128'h0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [127:0] w);
    fifo_q.push_back(w);
    fifo_update();
  endtask

  // One pixel-clock cycle: drive inputs, sample the pop request before the
  // edge, retire the popped word after it, then check the delayed timing.
  task automatic cyc(input logic vs, input logic hs, input logic de, output logic popped);
    video_vs_in = vs;
    video_hs_in = hs;
    video_de_in = de;
    #1;
    popped = fifo_rd_en;
    @(posedge video_clk);
    #1;
    if (popped) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    fifo_update();
    chk("de_out_dly", {127'h0, video_de_out}, {127'h0, de});
    chk("hs_out_dly", {127'h0, video_hs_out}, {127'h0, hs});
    chk("vs_out_dly", {127'h0, video_vs_out}, {127'h0, vs});
  endtask

  task automatic hs_pulse();
    logic p;
    cyc(1'b0, 1'b1, 1'b0, p);
    cyc(1'b0, 1'b0, 1'b0, p);
    cyc(1'b0, 1'b0, 1'b0, p);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"},  {127'h0, fifo_rd_en},   128'h0);
    chk({tag, "_vs"},     {127'h0, video_vs_out}, 128'h0);
    chk({tag, "_hs"},     {127'h0, video_hs_out}, 128'h0);
    chk({tag, "_de"},     {127'h0, video_de_out}, 128'h0);
    chk({tag, "_data"},   {104'h0, video_data_out}, 128'h0);
    chk({tag, "_lreq"},   {127'h0, line_req},     128'h0);
    chk({tag, "_freq"},   {127'h0, frame_req},    128'h0);
    chk({tag, "_uflow"},  {127'h0, underflow},    128'h0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge video_clk) begin
    logic [23:0] e;
    if (video_rst_n) begin
      if (line_req)  lr_cnt++;
      if (frame_req) fr_cnt++;
      if (video_de_out) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pixel_unexpected: got %06h, no pixel expected (t=%0t)", video_data_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", {104'h0, video_data_out}, {104'h0, e});
        end
      end else begin
        chk("blank_data_zero", {104'h0, video_data_out}, 128'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p;
    int pop0, lr0, fr0;

    // ---------------- reset state ----------------
    push_word(128'hFF112233_FF445566_FF778899_FFAABBCC);
    video_de_in = 1'b1;
    video_hs_in = 1'b1;
    @(posedge video_clk);
    #1;
    chk_reset_outputs("reset");
    video_de_in = 1'b0;
    video_hs_in = 1'b0;
    @(posedge video_clk);
    #1;
    video_rst_n = 1'b1;

    // ---------------- test 1: single word unpack ----------------
    lr0 = lr_cnt;
    hs_pulse();
    chk("t1_line_req_once", 128'(lr_cnt - lr0), 128'd1);
    exp_q.push_back(24'h112233);
    exp_q.push_back(24'h445566);
    exp_q.push_back(24'h778899);
    exp_q.push_back(24'hAABBCC);
    cyc(1'b0, 1'b0, 1'b1, p); chk("t1_pop_first", {127'h0, p}, 128'd1);
    cyc(1'b0, 1'b0, 1'b1, p); chk("t1_nopop_1",  {127'h0, p}, 128'd0);
    cyc(1'b0, 1'b0, 1'b1, p); chk("t1_nopop_2",  {127'h0, p}, 128'd0);
    cyc(1'b0, 1'b0, 1'b1, p); chk("t1_nopop_3",  {127'h0, p}, 128'd0);
    cyc(1'b0, 1'b0, 1'b0, p);

    // ---------------- test 2: full 1280-pixel line ----------------
    for (int i = 0; i < 320; i++)
      push_word(mk_word(pix(4*i), pix(4*i+1), pix(4*i+2), pix(4*i+3)));
    pop0 = pop_cnt;
    lr0  = lr_cnt;
    hs_pulse();
    for (int n = 0; n < 1280; n++) begin
      exp_q.push_back(pix(n));
      cyc(1'b0, 1'b0, 1'b1, p);
    end
    cyc(1'b0, 1'b0, 1'b0, p);
    chk("t2_pops",        128'(pop_cnt - pop0), 128'd320);
    chk("t2_underflow",   {127'h0, underflow}, 128'd0);
    chk("t2_line_req",    128'(lr_cnt - lr0), 128'd1);
    chk("t2_fifo_drained", 128'(fifo_q.size()), 128'd0);

    // ---------------- test 3: empty FIFO at line start ----------------
    pop0 = pop_cnt;
    hs_pulse();
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(FILL);
      cyc(1'b0, 1'b0, 1'b1, p);
    end
    cyc(1'b0, 1'b0, 1'b0, p);
    chk("t3_no_pop",       128'(pop_cnt - pop0), 128'd0);
    chk("t3_underflow_set", {127'h0, underflow}, 128'd1);
    cyc(1'b0, 1'b0, 1'b0, p);
    chk("t3_underflow_sticky", {127'h0, underflow}, 128'd1);
    underflow_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, p);
    underflow_clr = 1'b0;
    chk("t3_underflow_clr", {127'h0, underflow}, 128'd0);

    // ---------------- test 4: hs resync mid-word ----------------
    push_word(mk_word(24'h0A0001, 24'h0A0002, 24'h0A0003, 24'h0A0004));
    push_word(mk_word(24'h0B0001, 24'h0B0002, 24'h0B0003, 24'h0B0004));
    push_word(mk_word(24'h0C0001, 24'h0C0002, 24'h0C0003, 24'h0C0004));
    pop0 = pop_cnt;
    hs_pulse();
    exp_q.push_back(24'h0A0001); exp_q.push_back(24'h0A0002);
    exp_q.push_back(24'h0A0003); exp_q.push_back(24'h0A0004);
    exp_q.push_back(24'h0B0001); exp_q.push_back(24'h0B0002);
    for (int n = 0; n < 6; n++) cyc(1'b0, 1'b0, 1'b1, p);
    hs_pulse();
    exp_q.push_back(24'h0C0001); exp_q.push_back(24'h0C0002);
    exp_q.push_back(24'h0C0003); exp_q.push_back(24'h0C0004);
    cyc(1'b0, 1'b0, 1'b1, p); chk("t4_pop_after_resync", {127'h0, p}, 128'd1);
    for (int n = 0; n < 3; n++) cyc(1'b0, 1'b0, 1'b1, p);
    cyc(1'b0, 1'b0, 1'b0, p);
    chk("t4_pops", 128'(pop_cnt - pop0), 128'd3);

    // ---------------- test 5: reset mid-line ----------------
    push_word(mk_word(24'h0E0001, 24'h0E0002, 24'h0E0003, 24'h0E0004));
    push_word(mk_word(24'h0F0001, 24'h0F0002, 24'h0F0003, 24'h0F0004));
    hs_pulse();
    exp_q.push_back(24'h0E0001); exp_q.push_back(24'h0E0002);
    cyc(1'b0, 1'b0, 1'b1, p);
    cyc(1'b0, 1'b0, 1'b1, p);
    cyc(1'b0, 1'b0, 1'b0, p);
    video_rst_n = 1'b0;
    video_de_in = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk_reset_outputs("t5_in_reset");
      @(posedge video_clk);
      #1;
    end
    video_rst_n = 1'b1;
    pop0 = pop_cnt;
    exp_q.push_back(24'h0F0001); exp_q.push_back(24'h0F0002);
    exp_q.push_back(24'h0F0003); exp_q.push_back(24'h0F0004);
    cyc(1'b0, 1'b0, 1'b1, p); chk("t5_pop_after_release", {127'h0, p}, 128'd1);
    for (int n = 0; n < 3; n++) cyc(1'b0, 1'b0, 1'b1, p);
    cyc(1'b0, 1'b0, 1'b0, p);
    chk("t5_pops", 128'(pop_cnt - pop0), 128'd1);

    // ---------------- test 6: set beats clr, joint vs/hs edge ----------------
    push_word(mk_word(24'h0D0001, 24'h0D0002, 24'h0D0003, 24'h0D0004));
    hs_pulse();
    exp_q.push_back(24'h0D0001); exp_q.push_back(24'h0D0002);
    cyc(1'b0, 1'b0, 1'b1, p);
    cyc(1'b0, 1'b0, 1'b1, p);
    chk("t6_underflow_before", {127'h0, underflow}, 128'd0);
    lr0 = lr_cnt;
    fr0 = fr_cnt;
    underflow_clr = 1'b1;
    exp_q.push_back(FILL);
    cyc(1'b1, 1'b1, 1'b1, p);
    underflow_clr = 1'b0;
    chk("t6_no_pop_empty", {127'h0, p}, 128'd0);
    chk("t6_set_beats_clr", {127'h0, underflow}, 128'd1);
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(FILL);
      cyc(1'b0, 1'b0, 1'b1, p);
    end
    cyc(1'b0, 1'b0, 1'b0, p);
    cyc(1'b0, 1'b0, 1'b0, p);
    chk("t6_line_req_once",  128'(lr_cnt - lr0), 128'd1);
    chk("t6_frame_req_once", 128'(fr_cnt - fr0), 128'd1);

    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
